// File: rtl/tile_sel_gen_if.sv
// tile_sel_gen_if -- bundle of the tile selector's video-timing, map-write,
// player-position and output signals.
//
// Signals (direction as seen by the tile_sel_gen block):
//   i_hcount, i_vcount   in   11  current pixel position
//   i_hsync, i_vsync     in    1  sync inputs
//   i_hblnk, i_vblnk     in    1  blanking inputs
//   i_wr_en              in    1  map write strobe
//   i_wr_col, i_wr_row   in    4  map write cell
//   i_wr_type            in    4  tile code written to the map
//   i_plr*_col/row       in    4  player cells (used only with the overlay)
//   o_sel                out   4  tile select for the ROM RGB mux
//   o_rom_addr           out  10  tile-ROM address {y_off, x_off}
//   o_hcount, o_vcount   out  11  position aligned with o_sel
//   o_hsync .. o_vblnk   out   1  timing aligned with o_sel
//   o_busy               out   1  high while the map is being cleared
//
// Handshake: there is no valid/ready flow control. Every input is sampled on
// every pixel clock and every output is valid every cycle, two cycles after
// the inputs it was derived from. i_wr_en is a single-cycle write strobe.
interface tile_sel_gen_if;
  logic [10:0] i_hcount;
  logic [10:0] i_vcount;
  logic        i_hsync;
  logic        i_vsync;
  logic        i_hblnk;
  logic        i_vblnk;
  logic        i_wr_en;
  logic [3:0]  i_wr_col;
  logic [3:0]  i_wr_row;
  logic [3:0]  i_wr_type;
  logic [3:0]  i_plr1_col;
  logic [3:0]  i_plr1_row;
  logic [3:0]  i_plr2_col;
  logic [3:0]  i_plr2_row;
  logic [3:0]  o_sel;
  logic [9:0]  o_rom_addr;
  logic [10:0] o_hcount;
  logic [10:0] o_vcount;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_hblnk;
  logic        o_vblnk;
  logic        o_busy;

  modport master (
    output i_hcount, i_vcount, i_hsync, i_vsync, i_hblnk, i_vblnk,
    output i_wr_en, i_wr_col, i_wr_row, i_wr_type,
    output i_plr1_col, i_plr1_row, i_plr2_col, i_plr2_row,
    input  o_sel, o_rom_addr, o_hcount, o_vcount,
    input  o_hsync, o_vsync, o_hblnk, o_vblnk, o_busy
  );

  modport slave (
    input  i_hcount, i_vcount, i_hsync, i_vsync, i_hblnk, i_vblnk,
    input  i_wr_en, i_wr_col, i_wr_row, i_wr_type,
    input  i_plr1_col, i_plr1_row, i_plr2_col, i_plr2_row,
    output o_sel, o_rom_addr, o_hcount, o_vcount,
    output o_hsync, o_vsync, o_hblnk, o_vblnk, o_busy
  );
endinterface

// File: rtl/tile_sel_gen.sv
// tile_sel_gen -- maps the current pixel position onto a 16x12 board of
// 32x32 px tiles and emits the tile code and tile-ROM address for it.
//
// Ports:
//   i_pclk  in  pixel clock, the only clock
//   i_rst   in  synchronous active-high reset
//   bus     slave modport of tile_sel_gen_if (position/timing in, map
//           writes, player cells, tile select / ROM address / aligned
//           timing / busy out)
//
// Parameters: BOARD_X, BOARD_Y -- pixel of the board's left / top edge.
//
// Optional feature: define PLAYER_OVERLAY_EN to draw player 1 (code 5) and
// player 2 (code 6) over their map cells; player 1 wins on a shared cell.
//
// After reset the map is swept to PATH (one entry per cycle, 192 cycles)
// while o_busy is high; only then does the pipeline show map contents.
module tile_sel_gen #(
  parameter int BOARD_X = 256,
  parameter int BOARD_Y = 192
) (
  input  logic           i_pclk,
  input  logic           i_rst,
  tile_sel_gen_if.slave  bus
);

  localparam logic [3:0]  NO_TILE = 4'hF;
  localparam logic [3:0]  PATH    = 4'd0;
  localparam logic [7:0]  LAST_IX = 8'd191;
  localparam logic [11:0] X_LO    = 12'(BOARD_X);
  localparam logic [11:0] X_HI    = 12'(BOARD_X + 511);
  localparam logic [11:0] Y_LO    = 12'(BOARD_Y);
  localparam logic [11:0] Y_HI    = 12'(BOARD_Y + 383);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] clr_cnt;
  logic       busy;
  logic       clr_we;

  logic [3:0] map_mem [0:191];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_pclk) begin
    if (i_rst) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST_IX) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    if (state == ST_CLEAR) begin
      busy   = 1'b1;
      clr_we = 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst)                     clr_cnt <= 8'd0;
    else if (clr_we)               clr_cnt <= (clr_cnt == LAST_IX) ? 8'd0 : clr_cnt + 8'd1;
  end

  assign bus.o_busy = busy;

  // ------------------------------------------------------------ map write
  // The clear sweep owns the memory while busy; external writes only land
  // in RUN and only for rows that exist on the board.
  logic [7:0] wr_idx;
  assign wr_idx = {bus.i_wr_row, bus.i_wr_col};

  always_ff @(posedge i_pclk) begin
    if (clr_we)
      map_mem[clr_cnt] <= PATH;
    else if (!i_rst && bus.i_wr_en && (bus.i_wr_row <= 4'd11))
      map_mem[wr_idx] <= bus.i_wr_type;
  end

  // -------------------------------------------------------------- stage 1
  // Compare in 12 bits so positions left of / above the board cannot wrap
  // into range. The low 9 bits of the offset are all that col/off need.
  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        in_board;

  assign h_ext    = {1'b0, bus.i_hcount};
  assign v_ext    = {1'b0, bus.i_vcount};
  assign dx       = bus.i_hcount[8:0] - 9'(BOARD_X);
  assign dy       = bus.i_vcount[8:0] - 9'(BOARD_Y);
  assign in_board = (h_ext >= X_LO) && (h_ext <= X_HI) &&
                    (v_ext >= Y_LO) && (v_ext <= Y_HI);

  logic        s1_inb;
  logic [3:0]  s1_col;
  logic [3:0]  s1_row;
  logic [4:0]  s1_xoff;
  logic [4:0]  s1_yoff;
  logic [10:0] s1_h;
  logic [10:0] s1_v;
  logic [3:0]  s1_t;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      s1_inb  <= 1'b0;
      s1_col  <= 4'd0;
      s1_row  <= 4'd0;
      s1_xoff <= 5'd0;
      s1_yoff <= 5'd0;
      s1_h    <= 11'd0;
      s1_v    <= 11'd0;
      s1_t    <= 4'd0;
    end else begin
      s1_inb  <= in_board;
      s1_col  <= dx[8:5];
      s1_row  <= dy[8:5];
      s1_xoff <= dx[4:0];
      s1_yoff <= dy[4:0];
      s1_h    <= bus.i_hcount;
      s1_v    <= bus.i_vcount;
      s1_t    <= {bus.i_hsync, bus.i_vsync, bus.i_hblnk, bus.i_vblnk};
    end
  end

  // -------------------------------------------------------------- stage 2
  // The memory read is registered on the same edge as any write, so a
  // write to the cell being shown appears one cycle later.
  logic [7:0] rd_idx;
  logic [3:0] sel_c;
  assign rd_idx = {s1_row, s1_col};

  always_comb begin
    sel_c = map_mem[rd_idx];
`ifdef PLAYER_OVERLAY_EN
    if ((s1_col == bus.i_plr1_col) && (s1_row == bus.i_plr1_row))
      sel_c = 4'd5;
    else if ((s1_col == bus.i_plr2_col) && (s1_row == bus.i_plr2_row))
      sel_c = 4'd6;
`endif
  end

`ifndef PLAYER_OVERLAY_EN
  logic unused_plr;
  assign unused_plr = ^{bus.i_plr1_col, bus.i_plr1_row, bus.i_plr2_col, bus.i_plr2_row};
`endif

  logic [3:0] s2_t;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      bus.o_sel      <= NO_TILE;
      bus.o_rom_addr <= 10'd0;
      bus.o_hcount   <= 11'd0;
      bus.o_vcount   <= 11'd0;
      s2_t           <= 4'd0;
    end else begin
      bus.o_sel      <= (!busy && s1_inb) ? sel_c : NO_TILE;
      bus.o_rom_addr <= s1_inb ? {s1_yoff, s1_xoff} : 10'd0;
      bus.o_hcount   <= s1_h;
      bus.o_vcount   <= s1_v;
      s2_t           <= s1_t;
    end
  end

  assign bus.o_hsync = s2_t[3];
  assign bus.o_vsync = s2_t[2];
  assign bus.o_hblnk = s2_t[1];
  assign bus.o_vblnk = s2_t[0];

endmodule

// File: tb/tb_tile_sel_gen.sv
module tb_tile_sel_gen;

  localparam int BX = 256;
  localparam int BY = 192;
  localparam int EW = 41;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_sel_gen_if bus ();

  tile_sel_gen #(.BOARD_X(BX), .BOARD_Y(BY)) dut (
    .i_pclk (clk),
    .i_rst  (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  // The board as a plain array of tile codes; the two-cycle delay is a
  // "previous pixel" record plus the expected queue.
  int         m_clear_left;
  logic [3:0] m_map [192];
  logic       p_inb;
  int         p_col, p_row;
  logic [9:0] p_rom;
  logic [10:0] p_h, p_v;
  logic [3:0] p_t;
  logic [EW-1:0] exp_q[$];

  task automatic model_edge();
    int dx, dy;
    logic c_inb;
    logic [3:0] sel;
    logic [9:0] rom;
    logic [10:0] oh, ov;
    logic [3:0] ot;
    logic ob;
    dx = int'(bus.i_hcount) - BX;
    dy = int'(bus.i_vcount) - BY;
    c_inb = (dx >= 0) && (dx < 512) && (dy >= 0) && (dy < 384);
    if (rst) begin
      sel = 4'hF; rom = '0; oh = '0; ov = '0; ot = '0; ob = 1'b1;
      m_clear_left = 192;
      for (int i = 0; i < 192; i++) m_map[i] = 4'd0;
      p_inb = 1'b0; p_col = 0; p_row = 0; p_rom = '0; p_h = '0; p_v = '0; p_t = '0;
    end else begin
      sel = 4'hF;
      if (m_clear_left == 0 && p_inb) begin
        sel = m_map[p_row * 16 + p_col];
`ifdef PLAYER_OVERLAY_EN
        if (p_col == int'(bus.i_plr1_col) && p_row == int'(bus.i_plr1_row)) sel = 4'd5;
        else if (p_col == int'(bus.i_plr2_col) && p_row == int'(bus.i_plr2_row)) sel = 4'd6;
`endif
      end
      rom = p_inb ? p_rom : 10'd0;
      oh = p_h; ov = p_v; ot = p_t;
      if (m_clear_left == 0) begin
        if (bus.i_wr_en && bus.i_wr_row <= 4'd11)
          m_map[int'(bus.i_wr_row) * 16 + int'(bus.i_wr_col)] = bus.i_wr_type;
      end else begin
        m_clear_left--;
      end
      ob = (m_clear_left > 0);
      p_inb = c_inb;
      p_col = dx / 32; p_row = dy / 32;
      p_rom = {5'(dy % 32), 5'(dx % 32)};
      p_h = bus.i_hcount; p_v = bus.i_vcount;
      p_t = {bus.i_hsync, bus.i_vsync, bus.i_hblnk, bus.i_vblnk};
    end
    exp_q.push_back({sel, rom, oh, ov, ot, ob});
  endtask

  task automatic scoreboard();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("sel",    32'(bus.o_sel),      32'(e[40:37]));
    check("rom",    32'(bus.o_rom_addr), 32'(e[36:27]));
    check("hcount", 32'(bus.o_hcount),   32'(e[26:16]));
    check("vcount", 32'(bus.o_vcount),   32'(e[15:5]));
    check("timing", 32'({bus.o_hsync, bus.o_vsync, bus.o_hblnk, bus.o_vblnk}), 32'(e[4:1]));
    check("busy",   32'(bus.o_busy),     32'(e[0]));
  endtask

  // ------------------------------------------------------------- drivers
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    scoreboard();
  endtask

  task automatic set_pos(input int h, input int v);
    bus.i_hcount = 11'(h);
    bus.i_vcount = 11'(v);
  endtask

  task automatic set_wr(input logic en, input int col, input int row, input int typ);
    bus.i_wr_en   = en;
    bus.i_wr_col  = 4'(col);
    bus.i_wr_row  = 4'(row);
    bus.i_wr_type = 4'(typ);
  endtask

  task automatic set_plr(input int c1, input int r1, input int c2, input int r2);
    bus.i_plr1_col = 4'(c1); bus.i_plr1_row = 4'(r1);
    bus.i_plr2_col = 4'(c2); bus.i_plr2_row = 4'(r2);
  endtask

  task automatic drive_random();
    set_pos($urandom_range(BX + 560, BX - 40), $urandom_range(BY + 420, BY - 40));
    bus.i_hsync = 1'($urandom); bus.i_vsync = 1'($urandom);
    bus.i_hblnk = 1'($urandom); bus.i_vblnk = 1'($urandom);
    set_wr($urandom_range(9, 0) < 3, $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0));
    set_plr($urandom_range(15, 0), $urandom_range(13, 0), $urandom_range(15, 0), $urandom_range(13, 0));
  endtask

  task automatic reset_and_count_busy(input int hold);
    int busy_n;
    rst = 1'b1;
    for (int i = 0; i < hold; i++) cycle();
    rst = 1'b0;
    busy_n = bus.o_busy ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (i == 150) bus.i_wr_en = 1'b0;
      if (bus.o_busy) busy_n++;
    end
    check("busy_cycles", 32'(busy_n), 32'd192);
    check("busy_low_after_clear", 32'(bus.o_busy), 32'd0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    set_pos(0, 0);
    bus.i_hsync = 0; bus.i_vsync = 0; bus.i_hblnk = 0; bus.i_vblnk = 0;
    set_wr(0, 0, 0, 0);
    set_plr(15, 15, 15, 15);

    // reset values, then the clear sweep with sel held at no-tile
    for (int i = 0; i < 3; i++) cycle();
    check("rst_sel", 32'(bus.o_sel), 32'hF);
    check("rst_busy", 32'(bus.o_busy), 32'd1);
    reset_and_count_busy(2);

    // write (3,2)=OBS1 then look at pixel (+100,+70)
    set_wr(1, 3, 2, 1); cycle();
    set_wr(0, 0, 0, 0); set_pos(BX + 100, BY + 70);
    cycle(); cycle();
    check("d_sel_obs1", 32'(bus.o_sel), 32'd1);
    check("d_rom_6_4", 32'(bus.o_rom_addr), 32'({5'd6, 5'd4}));

    // write to the cell being read: old value first, new value next
    set_wr(1, 3, 2, 3); cycle();
    check("rbw_old", 32'(bus.o_sel), 32'd1);
    set_wr(0, 0, 0, 0); cycle();
    check("rbw_new", 32'(bus.o_sel), 32'd3);

    // row beyond the board must not alias into the map
    set_wr(1, 3, 12, 7); cycle(); set_wr(0, 0, 0, 0); cycle();
    check("row12_ignored", 32'(bus.o_sel), 32'd3);

    // edges just outside and just inside the board
    set_pos(BX - 1, BY + 70); cycle(); cycle();
    check("left_out_sel", 32'(bus.o_sel), 32'hF);
    check("left_out_rom", 32'(bus.o_rom_addr), 32'd0);
    set_pos(BX + 512, BY + 70); cycle(); cycle();
    check("right_out_sel", 32'(bus.o_sel), 32'hF);
    check("right_out_rom", 32'(bus.o_rom_addr), 32'd0);
    set_pos(BX + 511, BY + 383); cycle(); cycle();
    check("corner_in_rom", 32'(bus.o_rom_addr), 32'h3FF);
    set_pos(BX + 100, BY + 384); cycle(); cycle();
    check("bottom_out_sel", 32'(bus.o_sel), 32'hF);

    // players over a cell holding OBS2
    set_wr(1, 5, 5, 2); cycle(); set_wr(0, 0, 0, 0);
    set_plr(5, 5, 5, 5); set_pos(BX + 5 * 32 + 9, BY + 5 * 32 + 17);
    cycle(); cycle();
`ifdef PLAYER_OVERLAY_EN
    check("overlay_plr1_wins", 32'(bus.o_sel), 32'd5);
`else
    check("no_overlay_map", 32'(bus.o_sel), 32'd2);
`endif
    set_plr(15, 15, 15, 15);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end

    // reset mid-clear at index 100, with writes pending the whole time
    set_wr(0, 0, 0, 0); set_plr(15, 15, 15, 15); set_pos(0, 0);
    rst = 1'b1; cycle(); rst = 1'b0;
    set_wr(1, 1, 1, 7);
    for (int i = 0; i < 100; i++) cycle();
    reset_and_count_busy(1);
    set_wr(0, 0, 0, 0); set_pos(BX + 37, BY + 37);
    cycle(); cycle();
    check("clear_write_lost", 32'(bus.o_sel), 32'd0);

    for (int i = 0; i < 500; i++) begin
      drive_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_sel_gen.md
TILE_SEL_GEN -- requirements
Module: tile_sel_gen

Interface
REQ-001 Parameter BOARD_X, default 256: x pixel of the board's left edge.
REQ-002 Parameter BOARD_Y, default 192: y pixel of the board's top edge.
REQ-003 Ports (clock and reset first):
- i_pclk  in  1  pixel clock; the block's only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_hcount, i_vcount  in  11 each  current pixel position.
- i_hsync, i_vsync, i_hblnk, i_vblnk  in  1 each  timing signals.
- i_wr_en  in  1  map write strobe.
- i_wr_col  in  4  write column, 0..15.
- i_wr_row  in  4  write row, 0..11.
- i_wr_type  in  4  tile code written to the map.
- i_plr1_col, i_plr1_row, i_plr2_col, i_plr2_row  in  4 each  player cells.
- o_sel  out  4  tile select for the ROM RGB mux.
- o_rom_addr  out  10  tile-ROM address {y_off[4:0], x_off[4:0]}.
- o_hcount, o_vcount  out  11 each  position delayed to align with o_sel.
- o_hsync, o_vsync, o_hblnk, o_vblnk  out  1 each  timing delayed to align with o_sel.
- o_busy  out  1  high while the map is being cleared.

Function
REQ-004 Board geometry:
- 16 columns x 12 rows of 32x32 px tiles.
- Covers x in [BOARD_X, BOARD_X+511] and y in [BOARD_Y, BOARD_Y+383].
REQ-005 Tile codes:
- 0 PATH, 1 OBS1, 2 OBS2, 3 BOMB, 4 EXPL, 5 PLR1, 6 PLR2, 7 BOBO, 8 BOLI.
- 4'hF means no tile.
REQ-006 Map storage: 192 x 4-bit entries, index = row*16 + col.
REQ-007 Stage 1 (registered):
- col = (hcount-BOARD_X)>>5, row = (vcount-BOARD_Y)>>5.
- x_off and y_off = low 5 bits of the respective offset.
- Registers an in-board flag, true only inside the REQ-004 region, using unsigned compares with no wrap.
REQ-008 Stage 2 (registered):
- o_sel = map[index] when in-board, else 4'hF.
- o_rom_addr = {y_off, x_off} when in-board, else 0.
REQ-009 Latency:
- Exactly 2 i_pclk cycles from i_hcount/i_vcount to o_sel/o_rom_addr.
- All o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk are delayed by the same 2 cycles.
REQ-010 Blanking does not gate o_sel; o_sel is driven by position only.
REQ-011 Writes:
- When i_wr_en=1 in state RUN with col<=15 and row<=11, map[index] takes i_wr_type at the clock edge.
- Writes with row>11 are ignored.
REQ-012 Simultaneous write and stage-2 read of the same cell: the read returns the old value (read-before-write); the new value is visible from the next cycle.
REQ-013 State machine states: CLEAR and RUN.
REQ-014 CLEAR:
- A counter sweeps indices 0..191, writing PATH, one entry per cycle.
- o_busy=1; o_sel=4'hF; i_wr_en is ignored.
- After index 191 is written, the block moves to RUN.
REQ-015 RUN: o_busy=0; pipeline and writes operate per REQ-007 to REQ-012.
REQ-016 i_rst asserted in any state, including mid-CLEAR, restarts CLEAR at index 0.

Reset
REQ-017 While i_rst=1 and on the first cycle after, the block holds:
- state=CLEAR, clear counter=0, o_busy=1.
- o_sel=4'hF, o_rom_addr=0.
- all delayed position and timing outputs=0.
REQ-018 After i_rst is released, CLEAR lasts 192 cycles, then RUN.

Configuration
REQ-019 Macro PLAYER_OVERLAY_EN:
- Defined: in stage 2, an in-board cell equal to (i_plr1_col, i_plr1_row) yields o_sel=5 and one equal to (i_plr2_col, i_plr2_row) yields o_sel=6.
- Defined: player 1 wins if both players occupy the same cell.
- Defined: the map contents are not modified by the overlay.
- Not defined: the player ports exist but are ignored, and o_sel comes from the map only.

Verification
REQ-020 Reset, then 192 cycles: o_busy=1 for exactly 192 cycles after i_rst falls, then 0; o_sel=4'hF throughout.
REQ-021 Write col=3, row=2, type=1, then drive hcount=BOARD_X+100, vcount=BOARD_Y+70 -> two cycles later o_sel=1 and o_rom_addr={5'd6, 5'd4}.
REQ-022 hcount=BOARD_X-1, then BOARD_X+512 -> o_sel=4'hF and o_rom_addr=0 for both.
REQ-023 Write type=3 to the cell being read in the same cycle -> o_sel shows the old value, then 3 on the next read of that cell.
REQ-024 Assert i_rst at clear index 100 -> CLEAR restarts; o_busy stays high for a further 192 cycles; writes issued during that time are lost.
REQ-025 With PLAYER_OVERLAY_EN, both players at col 5, row 5, map cell=2 -> o_sel=5 there; the same bench without the macro gives o_sel=2.
